register_file_sb: RTL and testbench
===================================

# register_file_sb

Parametrised successor to the MIPS register file: configurable width and depth, two combinational read ports, optional write-to-read bypass, hardwired zero register, a per-register pending-write scoreboard for pipeline hazard detection, and a sequenced clear-all sweep. It sits in the decode stage of the pipelined core, between the instruction decoder and the ALU operand muxes.

## Interface
- N, default 32: data width in bits.
- DEPTH, default 32: number of registers; must be a power of two, at least 2.
- ADDR_W, default $clog2(DEPTH): register address width (derived).
- BYPASS, default 1: 1 forwards same-cycle write data to read ports; 0 means reads see stored contents only.
- ZERO_REG, default 1: 1 hardwires register 0 to zero, never writable or reservable.

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- Reg_Write_i  in  1  write enable.
- Write_Register_i  in  ADDR_W  write address.
- Write_Data_i  in  N  write data.
- Reserve_i  in  1  marks a register as having an in-flight producer.
- Reserve_Register_i  in  ADDR_W  register to reserve.
- Clear_i  in  1  one-cycle request to start the clear-all sweep.
- Read_Register_1_i  in  ADDR_W  read address, port 1.
- Read_Register_2_i  in  ADDR_W  read address, port 2.
- Read_Data_1_o  out  N  read data, port 1.
- Read_Data_2_o  out  N  read data, port 2.
- Busy_1_o  out  1  pending bit for the port 1 address.
- Busy_2_o  out  1  pending bit for the port 2 address.
- Clear_Busy_o  out  1  high while the clear sweep runs.

## Operation
- **Storage.** DEPTH x N registers plus a DEPTH-bit pending vector.
- **Write.** On a rising edge with Reg_Write_i=1 and state IDLE:
  - mem[Write_Register_i] <= Write_Data_i
  - pending[Write_Register_i] <= 0
- **Reserve.** On a rising edge with Reserve_i=1 and state IDLE: pending[Reserve_Register_i] <= 1.
- **Same-address write and reserve.** When both target the same register in one cycle, data is written and the pending bit ends at 1 (the reserve wins).
- **Register 0 (ZERO_REG=1).** Writes and reserves to address 0 are dropped. Reads of address 0 return 0, and Busy for it is 0.
- **Reads.** Combinational from the read addresses.
  - With BYPASS=1, state IDLE, Reg_Write_i=1 and Write_Register_i equal to the read address (non-zero): Read_Data_x_o = Write_Data_i and Busy_x_o = 0.
  - Otherwise Read_Data_x_o = mem[addr] and Busy_x_o = pending[addr].
  - Both ports may read the same address.
- **State machine (IDLE, CLEAR).**
  - IDLE to CLEAR: Clear_i=1 at a rising edge. The sweep counter loads 0.
  - In CLEAR, each cycle: mem[cnt] <= 0, pending[cnt] <= 0, cnt increments.
  - CLEAR to IDLE: on the edge that clears register DEPTH-1. The counter wraps to 0.
  - Reg_Write_i, Reserve_i and bypass are ignored during CLEAR, and so is Clear_i.
  - Reads during CLEAR return current contents: already-swept registers read 0, the rest keep old values.
- **Reset (reset=0, asynchronous).**
  - All mem = 0, pending = 0, state IDLE, counter 0.
  - Output values during reset: Read_Data_1_o/Read_Data_2_o = 0 (bypass suppressed), Busy_1_o/Busy_2_o = 0, Clear_Busy_o = 0.
  - Reset asserted mid-sweep aborts the sweep immediately.

## Timing
- Write to registered read: visible from the cycle after the write edge. With BYPASS=1 it is visible in the same cycle, combinationally.
- Reserve to Busy: Busy rises the cycle after the reserve edge.
- Write clearing Busy: bypassed same cycle with BYPASS=1, otherwise the next cycle.
- Clear_Busy_o is registered (Moore output):
  - It rises the cycle after Clear_i is sampled and stays high for exactly DEPTH cycles.
  - New writes are accepted on the first edge after it falls.
- Read paths are combinational: address to data is one LUT/mux level plus the bypass compare.

## Structure
- Package register_file_pkg holds:
  - the state enum (IDLE, CLEAR);
  - default constants DATA_W_DEF=32 and DEPTH_DEF=32;
  - the function used for the ADDR_W derivation.
- Sub-module register_file_scoreboard holds the pending vector, the set/clear priority logic and the busy lookups for both ports.
- The top level holds storage, bypass, the sweep FSM and the counter.

## Test plan
- Reset, then read addresses 0, 5 and 31 -> Read_Data = 0, all Busy = 0, Clear_Busy_o = 0.
- Write 0xDEADBEEF to 7, then read 7 on both ports next cycle -> both return 0xDEADBEEF. In the write cycle with BYPASS=1, port 1 already returns 0xDEADBEEF. Write 5 to register 0 -> a read of 0 returns 0.
- Reserve 9 -> Busy_1_o=1 next cycle. Write 0x3 to 9 -> Busy_1_o drops in the write cycle (BYPASS=1) and the read returns 3. Simultaneous write 0x4 and reserve to 9 -> data 4, Busy=1.
- Fill registers 1..31 with their index and reserve 10, then pulse Clear_i -> Clear_Busy_o high for 32 cycles, then:
  - register 20 reads 20 until swept, then 0;
  - a write of 0x55 to 3 during the sweep is dropped;
  - after the sweep every read returns 0 and Busy=0.
- Pulse Clear_i, then assert reset at sweep cycle 10 -> immediate all-zero outputs and state IDLE. After release, a write of 0x1 to 30 succeeds.
- Parameter variant N=16, DEPTH=8, BYPASS=0 -> write 0xABCD to 7, and the same-cycle read returns the old value 0. The next cycle returns 0xABCD.

Source files
------------

// File: rtl/register_file_pkg.sv
// register_file_pkg: shared state encoding, default sizes and address-width helper
package register_file_pkg;
    typedef enum logic {IDLE, CLEAR} state_t;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 32;
    function automatic int addr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction
endpackage

// File: rtl/register_file_scoreboard.sv
// register_file_scoreboard: per-register pending-write bits with set/clear priority and busy lookups
module register_file_scoreboard #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic              sweep,
    input  logic [ADDR_W-1:0] sweep_addr,
    input  logic [ADDR_W-1:0] rd_addr_1,
    input  logic [ADDR_W-1:0] rd_addr_2,
    input  logic              hit_1,
    input  logic              hit_2,
    output logic              busy_1,
    output logic              busy_2
);
    logic [DEPTH-1:0] pending, pending_nxt;
    // a reserve overrides a write to the same register; the sweep only runs while both are blocked
    always_comb begin
        pending_nxt = pending;
        if (clr) pending_nxt[clr_addr] = 1'b0;
        if (set) pending_nxt[set_addr] = 1'b1;
        if (sweep) pending_nxt[sweep_addr] = 1'b0;
    end
    // pending vector storage
    always_ff @(posedge clk or negedge reset)
        if (!reset) pending <= '0;
        else pending <= pending_nxt;
    assign busy_1 = pending[rd_addr_1] & ~hit_1;
    assign busy_2 = pending[rd_addr_2] & ~hit_2;
endmodule

// File: rtl/register_file_sb.sv
// register_file_sb: dual-read register file with bypass, zero register, scoreboard and clear sweep
module register_file_sb
    import register_file_pkg::*;
#(
    parameter int N        = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ADDR_W   = addr_width(DEPTH),
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Reg_Write_i,
    input  logic [ADDR_W-1:0] Write_Register_i,
    input  logic [N-1:0]      Write_Data_i,
    input  logic              Reserve_i,
    input  logic [ADDR_W-1:0] Reserve_Register_i,
    input  logic              Clear_i,
    input  logic [ADDR_W-1:0] Read_Register_1_i,
    input  logic [ADDR_W-1:0] Read_Register_2_i,
    output logic [N-1:0]      Read_Data_1_o,
    output logic [N-1:0]      Read_Data_2_o,
    output logic              Busy_1_o,
    output logic              Busy_2_o,
    output logic              Clear_Busy_o
);
    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [N-1:0]      mem [DEPTH];
    logic              idle, sweep, wr, rsv, hit_1, hit_2;

    assign idle  = state == IDLE;
    assign sweep = state == CLEAR;
    assign wr    = idle && Reg_Write_i && !(ZERO_REG != 0 && Write_Register_i == '0);
    assign rsv   = idle && Reserve_i && !(ZERO_REG != 0 && Reserve_Register_i == '0);
    // bypass is gated by reset so outputs read zero while reset is held
    assign hit_1 = BYPASS != 0 && reset && wr && Write_Register_i == Read_Register_1_i;
    assign hit_2 = BYPASS != 0 && reset && wr && Write_Register_i == Read_Register_2_i;
    assign Read_Data_1_o = hit_1 ? Write_Data_i : mem[Read_Register_1_i];
    assign Read_Data_2_o = hit_2 ? Write_Data_i : mem[Read_Register_2_i];

    // sweep sequencer: Clear_Busy_o mirrors the CLEAR state as a registered output
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            Clear_Busy_o <= 1'b0;
        end else if (idle) begin
            if (Clear_i) begin
                state        <= CLEAR;
                cnt          <= '0;
                Clear_Busy_o <= 1'b1;
            end
        end else begin
            cnt <= cnt + ADDR_W'(1);
            if (cnt == ADDR_W'(DEPTH - 1)) begin
                state        <= IDLE;
                Clear_Busy_o <= 1'b0;
            end
        end

    // storage: the sweep zeroes one register per cycle, otherwise accepted writes land
    always_ff @(posedge clk or negedge reset)
        if (!reset) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        else if (sweep) mem[cnt] <= '0;
        else if (wr) mem[Write_Register_i] <= Write_Data_i;

    register_file_scoreboard #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_sb (
        .clk       (clk),
        .reset     (reset),
        .set       (rsv),
        .set_addr  (Reserve_Register_i),
        .clr       (wr),
        .clr_addr  (Write_Register_i),
        .sweep     (sweep),
        .sweep_addr(cnt),
        .rd_addr_1 (Read_Register_1_i),
        .rd_addr_2 (Read_Register_2_i),
        .hit_1     (hit_1),
        .hit_2     (hit_2),
        .busy_1    (Busy_1_o),
        .busy_2    (Busy_2_o)
    );
endmodule

// File: tb/tb_register_file_sb.sv
// tb_register_file_sb: directed table, randomized model comparison and sweep/reset sequences
module tb_register_file_sb;
    logic        clk = 0, reset = 0;
    logic        we = 0, rs = 0, clr = 0;
    logic [4:0]  wa = 0, rsa = 0, r1 = 0, r2 = 0;
    logic [31:0] wd = 0;
    logic [31:0] d1, d2;
    logic        b1, b2, clear_busy;

    logic        s_we = 0, s_rs = 0, s_clr = 0;
    logic [2:0]  s_wa = 0, s_rsa = 0, s_r1 = 0, s_r2 = 0;
    logic [15:0] s_wd = 0, s_d1, s_d2;
    logic        s_b1, s_b2, s_cb;

    int vectors = 0, miscompares = 0;

    logic [31:0] m_mem [32];
    bit          m_pend [32];
    logic [31:0] o_d1, o_d2, e_d1, e_d2;
    bit          o_b1, o_b2, e_b1, e_b2;

    always #5 clk = ~clk;

    register_file_sb dut (
        .clk(clk), .reset(reset), .Reg_Write_i(we), .Write_Register_i(wa), .Write_Data_i(wd),
        .Reserve_i(rs), .Reserve_Register_i(rsa), .Clear_i(clr),
        .Read_Register_1_i(r1), .Read_Register_2_i(r2),
        .Read_Data_1_o(d1), .Read_Data_2_o(d2), .Busy_1_o(b1), .Busy_2_o(b2), .Clear_Busy_o(clear_busy)
    );

    register_file_sb #(.N(16), .DEPTH(8), .BYPASS(0)) u_small (
        .clk(clk), .reset(reset), .Reg_Write_i(s_we), .Write_Register_i(s_wa), .Write_Data_i(s_wd),
        .Reserve_i(s_rs), .Reserve_Register_i(s_rsa), .Clear_i(s_clr),
        .Read_Register_1_i(s_r1), .Read_Register_2_i(s_r2),
        .Read_Data_1_o(s_d1), .Read_Data_2_o(s_d2), .Busy_1_o(s_b1), .Busy_2_o(s_b2), .Clear_Busy_o(s_cb)
    );

    typedef struct {
        bit we; logic [4:0] wa; logic [31:0] wd; bit rs; logic [4:0] rsa;
        logic [4:0] r1, r2; logic [31:0] d1, d2; bit b1, b2;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i] = 0;
            m_pend[i] = 0;
        end
    endtask

    // one IDLE cycle: drive, sample outputs mid-cycle, predict from model, clock, update model
    task automatic step(input bit w, input logic [4:0] a, input logic [31:0] d, input bit r,
                        input logic [4:0] ra, input logic [4:0] p1, input logic [4:0] p2);
        we = w; wa = a; wd = d; rs = r; rsa = ra; r1 = p1; r2 = p2;
        @(negedge clk);
        o_d1 = d1; o_d2 = d2; o_b1 = b1; o_b2 = b2;
        e_d1 = (w && a != 0 && a == p1) ? d : m_mem[p1];
        e_d2 = (w && a != 0 && a == p2) ? d : m_mem[p2];
        e_b1 = (w && a != 0 && a == p1) ? 1'b0 : m_pend[p1];
        e_b2 = (w && a != 0 && a == p2) ? 1'b0 : m_pend[p2];
        @(posedge clk);
        #1;
        if (w && a != 0) begin
            m_mem[a] = d;
            m_pend[a] = 0;
        end
        if (r && ra != 0) m_pend[ra] = 1;
        we = 0; rs = 0;
    endtask

    initial begin
        int k;
        model_reset();
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 31, 31, 0, 0, 0, 0};
        tbl[2]  = '{1, 7, 32'hDEADBEEF, 0, 0, 7, 7, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0};
        tbl[3]  = '{1, 0, 5, 0, 0, 7, 0, 32'hDEADBEEF, 0, 0, 0};
        tbl[4]  = '{0, 0, 0, 1, 9, 9, 0, 0, 0, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 9, 0, 0, 0, 1, 0};
        tbl[6]  = '{1, 9, 3, 0, 0, 9, 7, 3, 32'hDEADBEEF, 0, 0};
        tbl[7]  = '{1, 9, 4, 1, 9, 9, 9, 4, 4, 0, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 9, 7, 4, 32'hDEADBEEF, 1, 0};
        tbl[9]  = '{0, 0, 0, 1, 0, 0, 9, 0, 4, 0, 1};
        tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        repeat (2) @(posedge clk);
        #1 reset = 1;
        @(negedge clk);
        chk("reset_clear_busy", {31'b0, clear_busy}, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].rs, tbl[i].rsa, tbl[i].r1, tbl[i].r2);
            chk($sformatf("tbl%0d_d1", i), o_d1, tbl[i].d1);
            chk($sformatf("tbl%0d_d2", i), o_d2, tbl[i].d2);
            chk($sformatf("tbl%0d_b1", i), {31'b0, o_b1}, {31'b0, tbl[i].b1});
            chk($sformatf("tbl%0d_b2", i), {31'b0, o_b2}, {31'b0, tbl[i].b2});
        end

        for (int i = 0; i < 300; i++) begin
            logic [4:0] a, p1, p2;
            a  = 5'($urandom_range(0, 31));
            p1 = ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, 31));
            p2 = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
            step(1'($urandom), a, $urandom, 1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)), p1, p2);
            chk("rand_d1", o_d1, e_d1);
            chk("rand_d2", o_d2, e_d2);
            chk("rand_b1", {31'b0, o_b1}, {31'b0, e_b1});
            chk("rand_b2", {31'b0, o_b2}, {31'b0, e_b2});
        end

        for (int i = 1; i < 32; i++) step(1, 5'(i), i, 0, 0, 0, 0);
        step(0, 0, 0, 1, 10, 10, 20);
        clr = 1;
        step(0, 0, 0, 0, 0, 10, 20);
        clr = 0;
        chk("pre_sweep_busy10", {31'b0, o_b1}, 1);
        chk("pre_sweep_r20", o_d2, 20);
        k = 0;
        r1 = 20; r2 = 3;
        while (k < 40) begin
            we = (k == 5); wa = 3; wd = 32'h55;
            @(negedge clk);
            if (!clear_busy) break;
            chk($sformatf("sweep%0d_r20", k), d1, (k <= 20) ? 32'd20 : 32'd0);
            if (k == 5) chk("sweep_write_r3", d2, 0);
            @(posedge clk);
            #1;
            k++;
        end
        we = 0;
        chk("sweep_len", k, 32);
        model_reset();
        for (int i = 0; i < 32; i += 2) begin
            step(0, 0, 0, 0, 0, 5'(i), 5'(i + 1));
            chk("post_d1", o_d1, 0);
            chk("post_d2", o_d2, 0);
            chk("post_busy", {30'b0, o_b1, o_b2}, 0);
        end

        step(1, 30, 32'h77, 1, 30, 0, 0);
        clr = 1;
        step(0, 0, 0, 0, 0, 0, 0);
        clr = 0;
        repeat (10) @(posedge clk);
        #1 we = 1; wa = 30; wd = 32'h99; r1 = 30; r2 = 30;
        #1;
        chk("sweep_unswept_d", d1, 32'h77);
        chk("sweep_unswept_busy", {31'b0, b1}, 1);
        chk("sweep_mid_busy", {31'b0, clear_busy}, 1);
        #1 reset = 0;
        #1;
        chk("rst_d1", d1, 0);
        chk("rst_d2", d2, 0);
        chk("rst_busy", {30'b0, b1, b2}, 0);
        chk("rst_clear_busy", {31'b0, clear_busy}, 0);
        model_reset();
        we = 0;
        @(posedge clk);
        #1 reset = 1;
        step(1, 30, 1, 0, 0, 30, 30);
        chk("after_rst_bypass", o_d1, 1);
        step(0, 0, 0, 0, 0, 30, 30);
        chk("after_rst_read", o_d1, 1);
        chk("after_rst_busy", {31'b0, o_b1}, 0);

        s_we = 1; s_wa = 7; s_wd = 16'hABCD; s_r1 = 7; s_r2 = 7;
        @(negedge clk);
        chk("small_same_cycle", {16'b0, s_d1}, 0);
        @(posedge clk);
        #1 s_we = 0;
        @(negedge clk);
        chk("small_next_cycle", {16'b0, s_d2}, 32'hABCD);
        s_rs = 1; s_rsa = 7;
        @(posedge clk);
        #1 s_rs = 0; s_we = 1; s_wd = 16'h1234;
        @(negedge clk);
        chk("small_busy_nobypass", {31'b0, s_b1}, 1);
        @(posedge clk);
        #1 s_we = 0; s_clr = 1;
        @(negedge clk);
        chk("small_busy_cleared", {31'b0, s_b1}, 0);
        @(posedge clk);
        #1 s_clr = 0;
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            if (!s_cb) break;
            @(posedge clk);
            #1 k++;
        end
        chk("small_sweep_len", k, 8);
        chk("small_swept", {16'b0, s_d1}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
